// File: rtl/mul_issue_wb_ctrl_pkg.sv
// Shared types and constants for the multiply issue/writeback controller
// and the pipelined multiplier it wraps.
package mul_pkg;
  localparam int XLEN        = 32;
  localparam int MUL_LATENCY = 4;
  localparam int TAG_W       = 5;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  // rs2 msb is all MULHSU needs to undo the signed treatment of rs2
  typedef struct packed {
    logic              vld;
    mul_op_e           op;
    logic [TAG_W-1:0]  rd;
    logic [XLEN-1:0]   rs1;
    logic              rs2_msb;
  } mul_tag_t;

  function automatic logic is_signed_op(input mul_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU);
  endfunction
endpackage

// File: rtl/mul_issue_wb_ctrl_if.sv
// Issue, multiplier and writeback signals of the multiply controller.
interface mul_issue_wb_ctrl_if #(
  parameter int XLEN  = mul_pkg::XLEN,
  parameter int TAG_W = mul_pkg::TAG_W
);
  logic              flush_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [1:0]        issue_op_i;
  logic [TAG_W-1:0]  issue_rd_i;
  logic [XLEN-1:0]   issue_rs1_i;
  logic [XLEN-1:0]   issue_rs2_i;
  logic              mul_start_o;
  logic              mul_signed_o;
  logic [XLEN-1:0]   mul_x_o;
  logic [XLEN-1:0]   mul_y_o;
  logic [2*XLEN-1:0] mul_product_i;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [TAG_W-1:0]  wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;

  modport slave (
    input  flush_i, issue_valid_i, issue_op_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
           mul_product_i, wb_ready_i,
    output issue_ready_o, mul_start_o, mul_signed_o, mul_x_o, mul_y_o,
           wb_valid_o, wb_rd_o, wb_data_o
  );

  modport master (
    output flush_i, issue_valid_i, issue_op_i, issue_rd_i, issue_rs1_i, issue_rs2_i,
           mul_product_i, wb_ready_i,
    input  issue_ready_o, mul_start_o, mul_signed_o, mul_x_o, mul_y_o,
           wb_valid_o, wb_rd_o, wb_data_o
  );
endinterface

// File: rtl/mul_wb_fifo.sv
// In-order result buffer; simultaneous push and pop is legal even when full.
module mul_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [W-1:0]           data_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign valid_o = (cnt_q != '0);
  assign do_pop  = pop_i && valid_o;
  assign count_o = cnt_q;
  // Head is forced to zero when empty so stale entries never leak out
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + AW'(1);
      if (do_pop) rptr_d = rptr_q + AW'(1);
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(push_i && !flush_i && full && !do_pop))
    else $error("mul_wb_fifo overflow");
endmodule

// File: rtl/mul_issue_wb_ctrl.sv
// Issue/writeback controller around a fixed-latency pipelined multiplier;
// credits cover in-flight plus buffered results since the multiplier cannot stall.
module mul_issue_wb_ctrl #(
  parameter int XLEN       = mul_pkg::XLEN,
  parameter int LATENCY    = mul_pkg::MUL_LATENCY,
  parameter int TAG_W      = mul_pkg::TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk_i,
  input logic                rst_n_i,
  mul_issue_wb_ctrl_if.slave bus
);
  localparam int CW  = $clog2(LATENCY + FIFO_DEPTH + 1);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  mul_pkg::mul_tag_t tag_q [LATENCY];
  mul_pkg::mul_tag_t tail;
  mul_pkg::mul_op_e  issue_op;
  logic              fire, push, pop, fifo_vld;
  logic [CW-1:0]     inflight, credits;
  logic [FCW-1:0]    fifo_cnt;
  logic [XLEN-1:0]   prod_lo, prod_hi, res;
  logic [TAG_W+XLEN-1:0] head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + CW'(tag_q[i].vld);
    credits = inflight + CW'(fifo_cnt);
  end

  assign issue_op          = mul_pkg::mul_op_e'(bus.issue_op_i);
  assign bus.issue_ready_o = rst_n_i && !bus.flush_i && (credits < CW'(FIFO_DEPTH));
  assign fire              = bus.issue_valid_i && bus.issue_ready_o;
  assign bus.mul_start_o   = fire;
  assign bus.mul_signed_o  = mul_pkg::is_signed_op(issue_op);
  assign bus.mul_x_o       = bus.issue_rs1_i;
  assign bus.mul_y_o       = bus.issue_rs2_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{vld: fire, op: issue_op, rd: bus.issue_rd_i,
                    rs1: bus.issue_rs1_i, rs2_msb: bus.issue_rs2_i[XLEN-1]};
      for (int i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (bus.flush_i)
        for (int i = 0; i < LATENCY; i++) tag_q[i].vld <= 1'b0;
    end
  end

  assign tail    = tag_q[LATENCY-1];
  assign prod_lo = bus.mul_product_i[XLEN-1:0];
  assign prod_hi = bus.mul_product_i[2*XLEN-1:XLEN];

  // Multiplier ran signed x signed for MULHSU; adding rs1 re-weights a negative rs2 as unsigned
  always_comb begin
    res = prod_hi;
    case (tail.op)
      mul_pkg::OP_MUL:    res = prod_lo;
      mul_pkg::OP_MULHSU: res = prod_hi + (tail.rs2_msb ? tail.rs1 : '0);
      default:            res = prod_hi;
    endcase
  end

  assign push = tail.vld && !bus.flush_i;
  assign pop  = fifo_vld && bus.wb_ready_i;

  mul_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(TAG_W + XLEN)) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (bus.flush_i),
    .push_i  (push),
    .data_i  ({tail.rd, res}),
    .pop_i   (pop),
    .valid_o (fifo_vld),
    .data_o  (head),
    .count_o (fifo_cnt)
  );

  assign bus.wb_valid_o = fifo_vld;
  assign bus.wb_rd_o    = head[TAG_W+XLEN-1:XLEN];
  assign bus.wb_data_o  = head[XLEN-1:0];
endmodule
